// File: rtl/pool_sched_pkg.sv
// Shared types and geometry helpers for the pooling-engine scheduler.
// FSM state enum plus output-map size functions.
package pool_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    ARM,
    WAIT,
    RESP
  } state_t;

  function automatic int calc_oh(int h, int pool, int stride);
    return (h - pool) / stride + 1;
  endfunction

  function automatic int calc_ow(int w, int pool, int stride);
    return (w - pool) / stride + 1;
  endfunction

  function automatic int calc_in_bits(int dw, int h, int w);
    return dw * h * w;
  endfunction

  function automatic int calc_out_bits(int dw, int oh, int ow);
    return dw * oh * ow;
  endfunction

endpackage

// File: rtl/pool_engine_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first set req bit at or after ptr.
// Ports: req, ptr in; one-hot grant, binary grant_idx, any out.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  always_comb begin
    int idx;
    idx       = 0;
    grant_idx = '0;
    any       = |req;
    // Scan from farthest to nearest so the
    // closest requester at/after ptr wins.
    for (int i = N - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % N;
      if (req[idx]) grant_idx = IW'(idx);
    end
    grant = any ? (N'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/pool_engine_scheduler.sv
// Round-robin scheduler sharing one pooling engine among N_REQ requesters.
// Ports: req_* (valid/ready in), rsp_* (valid/ready out), eng_* engine
// start/data/done, busy. Optional watchdog: define POOL_SCHED_TIMEOUT_EN.
module pool_engine_scheduler
  import pool_sched_pkg::*;
#(
  parameter  int N_REQ          = 4,
  parameter  int H              = 3,
  parameter  int W              = 4,
  parameter  int POOL_SIZE      = 2,
  parameter  int S              = 1,
  parameter  int DATA_WIDTH     = 8,
  parameter  int TIMEOUT_CYCLES = 1024,
  localparam int OH       = calc_oh(H, POOL_SIZE, S),
  localparam int OW       = calc_ow(W, POOL_SIZE, S),
  localparam int IN_BITS  = calc_in_bits(DATA_WIDTH, H, W),
  localparam int OUT_BITS = calc_out_bits(DATA_WIDTH, OH, OW),
  localparam int ID_W     = $clog2(N_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*IN_BITS-1:0] req_data,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [OUT_BITS-1:0]      rsp_data,
  output logic                     rsp_err,
  output logic                     busy,
  output logic                     eng_start,
  output logic [IN_BITS-1:0]       eng_input_data,
  input  logic [OUT_BITS-1:0]      eng_output_data,
  input  logic                     eng_done
);

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0] grant_idx;
  logic            any;
  logic [ID_W-1:0] next_ptr;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any)
  );

  // Gated by rst_n so no handshake is offered while held in reset.
  assign req_ready = (state == IDLE && rst_n) ? grant : '0;
  assign busy      = (state != IDLE);
  assign next_ptr  = (grant_idx == ID_W'(N_REQ - 1)) ?
                     '0 : grant_idx + 1'b1;

`ifdef POOL_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;
  logic          err_q;
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      rr_ptr         <= '0;
      rsp_id         <= '0;
      rsp_data       <= '0;
      rsp_valid      <= 1'b0;
      eng_start      <= 1'b0;
      eng_input_data <= '0;
`ifdef POOL_SCHED_TIMEOUT_EN
      wait_cnt       <= '0;
      err_q          <= 1'b0;
`endif
    end else begin
      eng_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any) begin
            eng_input_data <=
              req_data[int'(grant_idx)*IN_BITS +: IN_BITS];
            rsp_id    <= grant_idx;
            rr_ptr    <= next_ptr;
            eng_start <= 1'b1;
            state     <= ISSUE;
`ifdef POOL_SCHED_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
          end
        end
        ISSUE: state <= ARM;
        // eng_done may still be high from the previous job here.
        ARM:   state <= WAIT;
        WAIT: begin
          if (eng_done) begin
            rsp_data  <= eng_output_data;
            rsp_valid <= 1'b1;
            state     <= RESP;
`ifdef POOL_SCHED_TIMEOUT_EN
            err_q     <= 1'b0;
          end else if (wait_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            rsp_data  <= '0;
            rsp_valid <= 1'b1;
            err_q     <= 1'b1;
            state     <= RESP;
          end else begin
            wait_cnt  <= wait_cnt + 1'b1;
`endif
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pool_engine_scheduler.sv
// Self-checking bench for pool_engine_scheduler with a behavioural
// pooling-engine model, vector table, corner sequences and random traffic.
module tb_pool_engine_scheduler;

  localparam int N   = 4;
  localparam int H   = 3;
  localparam int W   = 4;
  localparam int P   = 2;
  localparam int S   = 1;
  localparam int DW  = 8;
  localparam int OH  = 2;
  localparam int OW  = 3;
  localparam int IB  = DW * H * W;
  localparam int OB  = DW * OH * OW;
  localparam int IDW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [N*IB-1:0] req_data;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [IDW-1:0] rsp_id;
  logic [OB-1:0] rsp_data;
  logic          rsp_err;
  logic          busy;
  logic          eng_start;
  logic [IB-1:0] eng_input_data;
  logic [OB-1:0] eng_output_data;
  logic          eng_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pool_engine_scheduler #(
    .N_REQ(N), .H(H), .W(W), .POOL_SIZE(P), .S(S),
    .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .eng_start(eng_start),
    .eng_input_data(eng_input_data),
    .eng_output_data(eng_output_data),
    .eng_done(eng_done)
  );

  // Floor-average pooling straight from the map definition.
  function automatic logic [OB-1:0] pool(input logic [IB-1:0] m);
    logic [OB-1:0] r;
    int sum;
    r = '0;
    for (int oy = 0; oy < OH; oy++)
      for (int ox = 0; ox < OW; ox++) begin
        sum = 0;
        for (int dy = 0; dy < P; dy++)
          for (int dx = 0; dx < P; dx++)
            sum += int'(m[IB-1-DW*((oy*S+dy)*W+ox*S+dx) -: DW]);
        r[OB-1-DW*(oy*OW+ox) -: DW] = DW'(sum / (P*P));
      end
    return r;
  endfunction

  function automatic logic [IB-1:0] fill(input logic [7:0] b);
    return {12{b}};
  endfunction

  // Engine model: done is a level, dropped one cycle after start is seen.
  int lat  = 3;
  bit hang = 1'b0;
  int ecnt;
  bit sd;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_done        <= 1'b0;
      eng_output_data <= '0;
      ecnt            <= 0;
      sd              <= 1'b0;
    end else begin
      if (sd) begin
        eng_done <= 1'b0;
        sd       <= 1'b0;
      end
      if (ecnt == 1 && !hang) begin
        eng_done        <= 1'b1;
        eng_output_data <= pool(eng_input_data);
      end
      if (ecnt > 0) ecnt <= ecnt - 1;
      if (eng_start) begin
        ecnt <= lat;
        sd   <= 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Raise a request and wait for its grant; returns at the ISSUE negedge.
  task automatic submit(input int id, input logic [IB-1:0] map,
                        input string tag);
    int n;
    n = 0;
    req_data[id*IB +: IB] = map;
    req_valid[id] = 1'b1;
    #1;
    while (!req_ready[id] && n < 60) begin
      @(negedge clk); #1; n++;
    end
    chk({tag, " grant"}, 128'(req_ready), 128'(1) << id);
    @(negedge clk);
    req_valid[id] = 1'b0;
    chk({tag, " start"}, 128'(eng_start), 128'(1));
    chk({tag, " eng_in"}, eng_input_data, map);
  endtask

  task automatic await_rsp(output int starts, input string tag);
    int n;
    n = 0;
    starts = 0;
    while (!rsp_valid && n < 200) begin
      if (eng_start) starts++;
      @(negedge clk); n++;
    end
    chk({tag, " rsp_valid"}, 128'(rsp_valid), 128'(1));
  endtask

  task automatic job(input int id, input logic [IB-1:0] map,
                     input logic [OB-1:0] exp, input string tag);
    int st;
    rsp_ready = 1'b1;
    submit(id, map, tag);
    await_rsp(st, tag);
    chk({tag, " id"}, 128'(rsp_id), 128'(id));
    chk({tag, " data"}, 128'(rsp_data), 128'(exp));
    chk({tag, " err"}, 128'(rsp_err), 128'(0));
    chk({tag, " starts"}, 128'(st), 128'(1));
    @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " ctl"},
        {req_ready, rsp_valid, rsp_id, rsp_err, busy, eng_start},
        '0);
    chk({tag, " rsp_data"}, 128'(rsp_data), '0);
    chk({tag, " eng_in"}, 128'(eng_input_data), '0);
  endtask

  typedef struct {
    int            id;
    logic [IB-1:0] map;
    logic [OB-1:0] exp;
  } vec_t;

  typedef struct {
    int            id;
    logic [OB-1:0] d;
  } exp_t;

  vec_t vt[4];
  exp_t exq[$];

  initial begin
    int st;
    int n;
    int g;
    int ptr_m;
    int grants;
    int starts;
    bit acc[N];
    logic [IB-1:0] pend[N];
    logic [IB-1:0] gmap;
    logic [IB-1:0] m;
    exp_t e;

    vt[0] = '{id: 0,
      map: {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6,
            8'd7, 8'd8, 8'd9, 8'd10, 8'd11, 8'd12},
      exp: {8'd3, 8'd4, 8'd5, 8'd7, 8'd8, 8'd9}};
    vt[1] = '{id: 1,
      map: {8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5,
            8'd6, 8'd7, 8'd8, 8'd9, 8'd10, 8'd11},
      exp: {8'd2, 8'd3, 8'd4, 8'd6, 8'd7, 8'd8}};
    vt[2] = '{id: 2, map: {12{8'hff}}, exp: {6{8'hff}}};
    vt[3] = '{id: 3,
      map: {3{8'hff, 8'h00, 8'hff, 8'h00}},
      exp: {6{8'h7f}}};

    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;

    // Table of single jobs, latency varied per entry.
    for (int i = 0; i < 4; i++) begin
      lat = 2 + i;
      job(vt[i].id, vt[i].map, vt[i].exp, $sformatf("vec%0d", i));
    end

    // Stale done: done still high from the last job while the new one starts.
    lat = 5;
    rsp_ready = 1'b1;
    submit(2, vt[0].map, "stale");
    @(negedge clk);
    chk("stale arm no rsp", 128'(rsp_valid), 128'(0));
    await_rsp(st, "stale");
    chk("stale data", 128'(rsp_data), 128'(vt[0].exp));
    chk("stale id", 128'(rsp_id), 128'(2));
    @(negedge clk);

    // Back-pressure with another requester waiting.
    lat = 3;
    rsp_ready = 1'b0;
    submit(1, vt[3].map, "bp");
    req_data[3*IB +: IB] = vt[1].map;
    req_valid[3] = 1'b1;
    await_rsp(st, "bp");
    for (int i = 0; i < 20; i++) begin
      chk("bp hold",
          {rsp_valid, rsp_id, rsp_data, req_ready, eng_start},
          {1'b1, 2'd1, vt[3].exp, 4'b0000, 1'b0});
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    job(3, vt[1].map, vt[1].exp, "bp next");

    // Round-robin from a fresh pointer, all requesters held valid.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    lat = 2;
    for (int k = 0; k < N; k++)
      req_data[k*IB +: IB] = fill(8'(10 * (k + 1)));
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int r = 0; r < 5; r++) begin
      n = 0;
      #1;
      while (req_ready == '0 && n < 60) begin
        @(negedge clk); #1; n++;
      end
      chk("rr grant", 128'(req_ready), 128'(1) << (r % N));
      @(negedge clk);
      if (r == 4) req_valid = '0;
      await_rsp(st, "rr");
      chk("rr id", 128'(rsp_id), 128'(r % N));
      chk("rr data", 128'(rsp_data),
          128'({6{8'(10 * (r % N + 1))}}));
      @(negedge clk);
    end

    // Reset while waiting on the engine; pointer must restart at 0.
    lat = 30;
    submit(2, vt[2].map, "rstw");
    req_data[0*IB +: IB] = vt[1].map;
    req_data[3*IB +: IB] = vt[0].map;
    req_valid[0] = 1'b1;
    req_valid[3] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rstw busy", 128'(busy), 128'(1));
    #2 rst_n = 1'b0;
    #1 chk_reset("rstw async");
    lat = 3;
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rstw regrant", 128'(req_ready), 128'(1));
    @(negedge clk);
    req_valid[0] = 1'b0;
    await_rsp(st, "rstw0");
    chk("rstw0 id", 128'(rsp_id), 128'(0));
    chk("rstw0 data", 128'(rsp_data), 128'(vt[1].exp));
    @(negedge clk);
    job(3, vt[0].map, vt[0].exp, "rstw3");

`ifdef POOL_SCHED_TIMEOUT_EN
    // Engine never completes: watchdog returns an error response.
    hang = 1'b1;
    rsp_ready = 1'b1;
    submit(1, vt[0].map, "tmo");
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(negedge clk); n++;
    end
    chk("tmo latency", 128'(n), 128'(18));
    chk("tmo err", 128'(rsp_err), 128'(1));
    chk("tmo data", 128'(rsp_data), '0);
    chk("tmo id", 128'(rsp_id), 128'(1));
    @(negedge clk);
    hang = 1'b0;
    job(2, vt[1].map, vt[1].exp, "tmo after");
`endif

    // Random traffic against a queue-based reference.
    ptr_m  = 0;
    grants = 0;
    starts = 0;
    gmap   = '0;
    for (int k = 0; k < N; k++) begin
      acc[k]  = 1'b0;
      pend[k] = '0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 2600; cyc++) begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        if (acc[k]) begin
          req_valid[k] = 1'b0;
          acc[k] = 1'b0;
        end else if (!req_valid[k] && cyc < 2000 &&
                     $urandom_range(0, 3) == 0) begin
          for (int b = 0; b < 12; b++)
            m[IB-1-8*b -: 8] = 8'($urandom);
          pend[k] = m;
          req_data[k*IB +: IB] = m;
          req_valid[k] = 1'b1;
        end
      end
      rsp_ready = (cyc >= 2000) || ($urandom_range(0, 2) != 0);
      lat = $urandom_range(2, 6);
      #1;
      if (eng_start) begin
        starts++;
        chk("rand eng_in", 128'(eng_input_data), 128'(gmap));
      end
      if (req_ready != '0) begin
        g = ptr_m;
        for (int i = 0; i < N; i++)
          if (!req_valid[g]) g = (g + 1) % N;
        chk("rand grant", 128'(req_ready), 128'(1) << g);
        acc[g] = 1'b1;
        ptr_m  = (g + 1) % N;
        gmap   = pend[g];
        grants++;
        exq.push_back('{id: g, d: pool(pend[g])});
      end
      if (rsp_valid && rsp_ready) begin
        if (exq.size() == 0) begin
          chk("rand unexpected rsp", 128'(1), 128'(0));
        end else begin
          e = exq.pop_front();
          chk("rand id", 128'(rsp_id), 128'(e.id));
          chk("rand data", 128'(rsp_data), 128'(e.d));
          chk("rand err", 128'(rsp_err), 128'(0));
        end
      end
    end
    chk("rand drained", 128'(exq.size()), 128'(0));
    chk("rand pending", 128'(req_valid), '0);
    chk("rand starts", 128'(starts), 128'(grants));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pool_engine_scheduler.md
# pool_engine_scheduler

Shares a single average-pooling engine among `N_REQ` requesters. Each requester submits a full feature map over a valid/ready handshake. The scheduler picks one request by round-robin, latches its map, starts the engine, waits for completion and returns the pooled map tagged with the requester index. It sits between the per-channel feature buffers and the pooling engine instance in the pooling subsystem.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (≥2)
- `H`, 3, input map height
- `W`, 4, input map width
- `POOL_SIZE`, 2, pooling window edge
- `S`, 1, stride
- `DATA_WIDTH`, 8, element width
- `TIMEOUT_CYCLES`, 1024, watchdog limit (used only with the timeout macro)
- Derived: `OH=(H-POOL_SIZE)/S+1`, `OW=(W-POOL_SIZE)/S+1`, `IN_BITS=DATA_WIDTH*H*W`, `OUT_BITS=DATA_WIDTH*OH*OW`, `ID_W=$clog2(N_REQ)`

Ports:
- `clk` in 1: clock
- `rst_n` in 1: reset, asynchronous, active-low
- `req_valid` in N_REQ: per-requester request valid
- `req_ready` out N_REQ: one-hot grant/accept
- `req_data` in N_REQ*IN_BITS: requester k's map at slice k, row-major, element 0 at MSB of the slice
- `rsp_valid` out 1: result valid
- `rsp_ready` in 1: result consumer ready
- `rsp_id` out ID_W: requester index of the result
- `rsp_data` out OUT_BITS: pooled map, same ordering as the engine output
- `rsp_err` out 1: timeout flag, valid with `rsp_valid`
- `busy` out 1: high whenever state ≠ IDLE
- `eng_start` out 1: engine start pulse
- `eng_input_data` out IN_BITS: held map to the engine
- `eng_output_data` in OUT_BITS: engine result
- `eng_done` in 1: engine done, a level that stays high until the next start

## Operation
- FSM states: IDLE, ISSUE, ARM, WAIT, RESP.
- **IDLE:** if any `req_valid`, the grant g is the first set bit at or after `rr_ptr`, searching cyclically.
  - `req_ready` is combinationally one-hot at g; the handshake completes in that cycle.
  - Latch `req_data[g]` into `eng_input_data`, set `rsp_id<=g`, `rr_ptr<=(g+1)%N_REQ`, go to ISSUE.
- **ISSUE:** `eng_start`=1 for exactly one cycle, then ARM.
- **ARM:** ignore `eng_done`, because it is still high from the previous job. Go to WAIT.
- **WAIT:** on `eng_done`=1, capture `eng_output_data` into `rsp_data` and go to RESP.
- **RESP:** `rsp_valid`=1, and `rsp_data`/`rsp_id`/`rsp_err` stay stable until `rsp_ready`. On handshake, go to IDLE.
- `eng_input_data` is held constant from the latch until the next grant. The engine reads it throughout processing.
- Requests without a grant are not dropped. They stay pending under valid/ready rules.
- `req_ready` is 0 in every state except IDLE. Only one job is in flight at a time.
- `rr_ptr` wraps from N_REQ-1 to 0.
- Reset mid-job: every register returns to its reset value. The engine shares `rst_n`, so no job is resumed.
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `rsp_err`=0, `busy`=0, `eng_start`=0, `eng_input_data`=0, `rr_ptr`=0, state=IDLE.

## Timing
- Grant is in cycle T (IDLE), `eng_start` in T+1, ARM in T+2, `eng_done` is first sampled in T+3.
- `rsp_valid` rises the cycle after `eng_done` is sampled high in WAIT.
- If `rsp_ready` is high when `rsp_valid` rises, the next grant can occur 1 cycle later (IDLE).
- Minimum request-to-request spacing is engine latency + 5 cycles.
- `eng_start` must never be asserted while state ≠ ISSUE.

## Configuration
- `POOL_SCHED_TIMEOUT_EN` defined:
  - A cycle counter runs in WAIT.
  - If `eng_done` is not seen within `TIMEOUT_CYCLES` cycles, go to RESP with `rsp_err`=1 and `rsp_data`=0.
  - The counter clears on entry to ISSUE.
- Not defined: no counter. WAIT lasts indefinitely and `rsp_err` is tied 0.

## Structure
- Package `pool_sched_pkg`: FSM state enum (`IDLE/ISSUE/ARM/WAIT/RESP`), plus functions computing `OH`, `OW`, `IN_BITS` and `OUT_BITS` from the parameters.
- Sub-module `rr_arbiter` (parameter N): inputs `req`, `ptr`; outputs one-hot `grant`, binary `grant_idx`, `any`. Purely combinational.
- The pooling engine is instantiated outside this block.

## Test plan
- **Single job:** requester 0 submits map 1..12 (defaults) → `rsp_id`=0, `rsp_data`={3,4,5,7,8,9}, `rsp_err`=0, exactly one `eng_start` pulse.
- **Round-robin:** all 4 requesters hold valid, each with a constant map (k+1)*10 → results in `rsp_id` order 0,1,2,3, each map all (k+1)*10. Then requester 0 is served again first after wrap.
- **Back-pressure:** hold `rsp_ready`=0 for 20 cycles after `rsp_valid` → `rsp_valid`, `rsp_data` and `rsp_id` stay stable, `req_ready` stays 0 and no `eng_start` occurs.
- **Stale done:** `eng_done` is still high from the previous job when a new job starts → no early capture; the result matches the new map.
- **Reset mid-WAIT:** deassert `rst_n` during WAIT → all outputs reach reset values asynchronously. After release, a pending request is granted starting from requester 0.
- **Timeout (macro on, `TIMEOUT_CYCLES`=16):** a stub engine never asserts `eng_done` → `rsp_valid` with `rsp_err`=1 and `rsp_data`=0, 16 cycles after entering WAIT.
